// File: rtl/controlador_interrupciones_pkg.sv
`default_nettype none
// ============================================================================
// Module      : controlador_interrupciones_pkg
// Description : Shared constants for the interrupt controller: FSM state
//               encodings, default handler vector layout and id-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package controlador_interrupciones_pkg;

    // FSM state encodings (kept as plain 2-bit constants for legacy tooling)
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_SERVICE = 2'd2;

    // Default handler table layout
    localparam int c_DEF_VEC_BASE   = 'h0F00;
    localparam int c_DEF_VEC_STRIDE = 4;

    // Width of an interrupt index; never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : controlador_interrupciones_pkg
`default_nettype wire

// File: rtl/controlador_interrupciones_if.sv
`default_nettype none
// ============================================================================
// Module      : controlador_interrupciones_if
// Description : CPU/peripheral side bundle of the interrupt controller:
//               request lines, mask write port, ack/return handshake and the
//               registered status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface controlador_interrupciones_if #(
    parameter int N_IRQ = 8,
    parameter int AW    = 16
);
    localparam int IDW = controlador_interrupciones_pkg::id_width(N_IRQ);

    logic [N_IRQ-1:0] interrupcion;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             irq_ack;
    logic             irq_ret;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] pending;
    logic             irq_req;
    logic [IDW-1:0]   irq_id;
    logic [AW-1:0]    irq_vec;
    logic             busy;

    // Environment / CPU side
    modport master (
        output interrupcion, mask_we, mask_wdata, irq_ack, irq_ret,
        input  mask, pending, irq_req, irq_id, irq_vec, busy
    );

    // Controller side
    modport slave (
        input  interrupcion, mask_we, mask_wdata, irq_ack, irq_ret,
        output mask, pending, irq_req, irq_id, irq_vec, busy
    );
endinterface : controlador_interrupciones_if
`default_nettype wire

// File: rtl/controlador_interrupciones_codificador_prioridad.sv
`default_nettype none
// ============================================================================
// Module      : codificador_prioridad
// Description : Combinational fixed-priority encoder, lowest index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module codificador_prioridad #(
    parameter int N_IRQ = 8,
    parameter int IDW   = 3
) (
    input  wire logic [N_IRQ-1:0] i_req,
    output logic                  o_valid,
    output logic [IDW-1:0]        o_id
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        o_valid = |i_req;
        o_id    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = IDW'(i);
            end
        end
    end

endmodule : codificador_prioridad
`default_nettype wire

// File: rtl/controlador_interrupciones.sv
`default_nettype none
// ============================================================================
// Module      : controlador_interrupciones
// Description : Maskable fixed-priority interrupt controller. Latches request
//               lines (edge or level), arbitrates the enabled ones and presents
//               one request at a time as a handler address, holding it until
//               the CPU acknowledges and later returns from the handler.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_interrupciones
    import controlador_interrupciones_pkg::*;
#(
    parameter int N_IRQ      = 8,
    parameter int AW         = 16,
    parameter int VEC_BASE   = c_DEF_VEC_BASE,
    parameter int VEC_STRIDE = c_DEF_VEC_STRIDE,
    parameter bit EDGE_MODE  = 1'b1
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    controlador_interrupciones_if.slave bus
);

    localparam int IDW = id_width(N_IRQ);

    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_pending;
    logic [1:0]       r_state;
    logic             r_req;
    logic [IDW-1:0]   r_id;
    logic [AW-1:0]    r_vec;
    logic             r_busy;

    logic [N_IRQ-1:0] w_masked;
    logic             w_valid;
    logic [IDW-1:0]   w_win_id;
    logic [AW-1:0]    w_win_vec;
    logic             w_ack_take;
    logic             w_ret_take;

    // Mask gates only arbitration; pending bits latch regardless
    assign w_masked   = r_pending & r_mask;
    // Ack/ret are honoured only in the state where they make sense
    assign w_ack_take = (r_state == c_ST_REQ)     && bus.irq_ack;
    assign w_ret_take = (r_state == c_ST_SERVICE) && bus.irq_ret;

    codificador_prioridad #(
        .N_IRQ (N_IRQ),
        .IDW   (IDW)
    ) u_prio (
        .i_req   (w_masked),
        .o_valid (w_valid),
        .o_id    (w_win_id)
    );

    // Handler address, naturally truncated to AW bits
    assign w_win_vec = AW'(VEC_BASE) + AW'(w_win_id) * AW'(VEC_STRIDE);

    // Mask register: writable in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
        end else if (bus.mask_we) begin
            r_mask <= bus.mask_wdata;
        end
    end

    generate
        if (EDGE_MODE) begin : g_edge
            logic [N_IRQ-1:0] r_prev;
            logic [N_IRQ-1:0] w_clr;
            logic [N_IRQ-1:0] w_set;

            assign w_set = bus.interrupcion & ~r_prev;
            assign w_clr = w_ack_take ? (N_IRQ'(1) << r_id) : '0;

            // Rising edges set pending; an accepted ack clears its line, a
            // simultaneous new edge on that same line takes precedence
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_prev    <= '0;
                    r_pending <= '0;
                end else begin
                    r_prev    <= bus.interrupcion;
                    r_pending <= (r_pending & ~w_clr) | w_set;
                end
            end
        end else begin : g_level
            // Level lines: pending simply follows the source, one cycle late
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pending <= '0;
                end else begin
                    r_pending <= bus.interrupcion;
                end
            end
        end
    endgenerate

    // Request / service sequencer; id and vector freeze once a request is up
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_req   <= 1'b0;
            r_id    <= '0;
            r_vec   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_valid) begin
                        r_state <= c_ST_REQ;
                        r_req   <= 1'b1;
                        r_id    <= w_win_id;
                        r_vec   <= w_win_vec;
                    end
                end
                c_ST_REQ: begin
                    if (w_ack_take) begin
                        r_state <= c_ST_SERVICE;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_SERVICE: begin
                    if (w_ret_take) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mask    = r_mask;
    assign bus.pending = r_pending;
    assign bus.irq_req = r_req;
    assign bus.irq_id  = r_id;
    assign bus.irq_vec = r_vec;
    assign bus.busy    = r_busy;

endmodule : controlador_interrupciones
`default_nettype wire

// File: tb/tb_controlador_interrupciones.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_interrupciones
// Description : Self-checking bench for controlador_interrupciones (edge mode,
//               8 lines) with directed scenarios and random traffic against a
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_interrupciones;

    localparam int N  = 8;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    controlador_interrupciones_if #(.N_IRQ(N), .AW(AW)) bus ();

    controlador_interrupciones #(
        .N_IRQ      (N),
        .AW         (AW),
        .VEC_BASE   ('h0F00),
        .VEC_STRIDE (4),
        .EDGE_MODE  (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase 0 = waiting, 1 = request shown, 2 = in handler
    int          m_phase;
    logic [7:0]  m_pend, m_prev, m_mask;
    int          m_id;
    logic [15:0] m_vec;
    logic        m_req, m_busy;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pend = '0; m_prev = '0; m_mask = '0;
        m_id = 0; m_vec = '0; m_req = 1'b0; m_busy = 1'b0;
    endtask

    // One clock edge of the controller as described by its rules
    task automatic model_edge(input logic [7:0] irq, input logic we, input logic [7:0] wd,
                              input logic ack, input logic ret);
        logic [7:0] cand;
        logic [7:0] clr;
        int         sel;
        if (reset) begin
            model_reset();
            return;
        end
        cand = m_pend & m_mask;
        sel  = -1;
        for (int i = 0; i < 8; i++) if (cand[i] && sel < 0) sel = i;
        clr = '0;
        if (m_phase == 0) begin
            if (sel >= 0) begin
                m_phase = 1; m_req = 1'b1; m_id = sel;
                m_vec = 16'(32'h0F00 + sel * 4);
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                m_phase = 2; m_req = 1'b0; m_busy = 1'b1; clr[m_id] = 1'b1;
            end
        end else begin
            if (ret) begin
                m_phase = 0; m_busy = 1'b0;
            end
        end
        m_pend = (m_pend & ~clr) | (irq & ~m_prev);
        m_prev = irq;
        if (we) m_mask = wd;
    endtask

    task automatic check_all();
        check_val("irq_req", 32'(bus.irq_req), 32'(m_req));
        check_val("busy",    32'(bus.busy),    32'(m_busy));
        check_val("pending", 32'(bus.pending), 32'(m_pend));
        check_val("mask",    32'(bus.mask),    32'(m_mask));
        check_val("irq_id",  32'(bus.irq_id),  32'(m_id));
        check_val("irq_vec", 32'(bus.irq_vec), 32'(m_vec));
    endtask

    // Drive inputs, take one edge, then compare 1 time unit later
    task automatic step(input logic [7:0] irq, input logic we = 1'b0, input logic [7:0] wd = 8'h00,
                        input logic ack = 1'b0, input logic ret = 1'b0);
        bus.interrupcion = irq;
        bus.mask_we      = we;
        bus.mask_wdata   = wd;
        bus.irq_ack      = ack;
        bus.irq_ret      = ret;
        @(posedge clk);
        model_edge(irq, we, wd, ack, ret);
        #1;
        check_all();
    endtask

    task automatic ack_ret();
        step(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] r_irq;
        logic       r_we, r_ack, r_ret;
        logic [7:0] r_wd;

        reset = 1'b1;
        bus.interrupcion = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
        bus.irq_ack = 1'b0; bus.irq_ret = 1'b0;
        model_reset();
        #1;
        step(8'h00);
        check_val("rst_req",  32'(bus.irq_req), 32'd0);
        check_val("rst_vec",  32'(bus.irq_vec), 32'd0);
        reset = 1'b0;

        // Single line 3
        step(8'h00, 1'b1, 8'hFF);
        step(8'h08);
        step(8'h00);
        check_val("t1_id",  32'(bus.irq_id),  32'd3);
        check_val("t1_vec", 32'(bus.irq_vec), 32'h0F0C);
        ack_ret();

        // Lines 5 and 1 together: 1 first, then 5 one edge after ret
        step(8'h22);
        step(8'h00);
        check_val("t2_vec1", 32'(bus.irq_vec), 32'h0F04);
        ack_ret();
        step(8'h00);
        check_val("t2_vec5", 32'(bus.irq_vec), 32'h0F14);
        ack_ret();

        // Masked line latches but is not requested until enabled
        step(8'h00, 1'b1, 8'h00);
        step(8'h04);
        step(8'h00);
        check_val("t3_pend", 32'(bus.pending), 32'h04);
        check_val("t3_noreq", 32'(bus.irq_req), 32'd0);
        step(8'h00, 1'b1, 8'h04);
        step(8'h00);
        check_val("t3_req", 32'(bus.irq_req), 32'd1);
        ack_ret();

        // Frozen id while a higher-priority line arrives
        step(8'h00, 1'b1, 8'hFF);
        step(8'h10);
        step(8'h00);
        step(8'h01);
        step(8'h00);
        check_val("t4_frozen", 32'(bus.irq_id), 32'd4);
        ack_ret();
        step(8'h00);
        check_val("t4_next", 32'(bus.irq_id), 32'd0);
        ack_ret();

        // Re-trigger of line 6 on its own ack edge
        step(8'h40);
        step(8'h00);
        step(8'h40, 1'b0, 8'h00, 1'b1, 1'b0);
        check_val("t5_pend6", 32'(bus.pending[6]), 32'd1);
        step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        step(8'h00);
        check_val("t5_rereq", 32'(bus.irq_id), 32'd6);
        ack_ret();

        // Stray handshakes while idle
        step(8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a handler
        step(8'h02);
        step(8'h00);
        step(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        step(8'h08);
        #2;
        reset = 1'b1;
        #1;
        check_val("ar_busy", 32'(bus.busy),    32'd0);
        check_val("ar_req",  32'(bus.irq_req), 32'd0);
        check_val("ar_pend", 32'(bus.pending), 32'd0);
        model_reset();
        check_all();
        step(8'h00);
        reset = 1'b0;
        step(8'h00, 1'b1, 8'hFF);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            r_irq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            r_we  = ($urandom_range(0, 19) == 0);
            r_wd  = 8'($urandom);
            r_ack = m_req  ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            r_ret = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            step(r_irq, r_we, r_wd, r_ack, r_ret);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_controlador_interrupciones
`default_nettype wire
